// File: rtl/matmul_pkg.sv
// Shared defaults and drain FSM encoding for the systolic matmul result path.
package matmul_pkg;

   localparam int DWIDTH_DEF       = 16;
   localparam int AWIDTH_DEF       = 7;
   localparam int MAT_MUL_SIZE_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      FLUSH = 2'd2,
      FIN   = 2'd3
   } drain_state_t;

endpackage

// File: rtl/matmul_drain_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and occupancy count.
module matmul_drain_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign do_push = push && (count_reg != CW'(DEPTH));
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
      end
   end

   // An empty FIFO presents zero so the stream data is clean after reset.
   assign pop_data = empty ? '0 : mem_reg[rd_ptr_reg];
   assign count    = count_reg;

endmodule

// File: rtl/matmul_result_drain.sv
// Reads the C matrix out of the shared BRAMs after matmul done and streams it with backpressure.
// Optional build macro MATMUL_DRAIN_RELU_EN clamps negative lanes to zero at FIFO write.
module matmul_result_drain
   import matmul_pkg::*;
#(
   parameter int DWIDTH       = DWIDTH_DEF,
   parameter int AWIDTH       = AWIDTH_DEF,
   parameter int MAT_MUL_SIZE = MAT_MUL_SIZE_DEF,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start_drain,
   input  logic [AWIDTH-1:0]              base_addr,
   input  logic [AWIDTH:0]                num_words,
   output logic                           enable_reading_from_mem,
   output logic [AWIDTH-1:0]              addr_pi,
   input  logic [MAT_MUL_SIZE*DWIDTH-1:0] data_from_out_mat,
   output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_last,
   output logic                           busy,
   output logic                           done
);

   localparam int WW = MAT_MUL_SIZE * DWIDTH;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int NW = AWIDTH + 1;

   drain_state_t      state_reg, state_next;
   logic [AWIDTH-1:0] addr_reg, addr_next;
   logic [NW-1:0]     num_reg, num_next;
   logic [NW-1:0]     issued_reg, issued_next;
   logic [NW-1:0]     popped_reg, popped_next;
   logic              inflight_reg;

   logic [CW-1:0]     fifo_count;
   logic              fifo_empty;
   logic [WW-1:0]     capture_data;
   logic [WW-1:0]     fifo_data;
   logic              issue;
   logic              pop;
   logic [CW:0]       count_next;
   logic              will_issue;

`ifdef MATMUL_DRAIN_RELU_EN
   genvar gi;
   generate
      for (gi = 0; gi < MAT_MUL_SIZE; gi++) begin : g_relu
         assign capture_data[gi*DWIDTH +: DWIDTH] =
            data_from_out_mat[gi*DWIDTH + DWIDTH - 1] ? '0 : data_from_out_mat[gi*DWIDTH +: DWIDTH];
      end
   endgenerate
`else
   assign capture_data = data_from_out_mat;
`endif

   matmul_drain_fifo #(
      .WIDTH (WW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (inflight_reg),
      .push_data (capture_data),
      .pop       (pop),
      .pop_data  (fifo_data),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = fifo_data;
   assign out_last  = out_valid && ((popped_reg + 1'b1) == num_reg);
   assign pop       = out_valid && out_ready;
   assign busy      = (state_reg != IDLE);
   assign done      = (state_reg == FIN);
   assign addr_pi   = addr_reg;

   // Credit check: words already buffered plus the one still in the BRAM pipe.
   assign issue = (state_reg == READ) && (issued_reg < num_reg) &&
                  (({1'b0, fifo_count} + (CW+1)'(inflight_reg)) < (CW+1)'(FIFO_DEPTH));

   assign enable_reading_from_mem = (state_reg == READ) || ((state_reg == FLUSH) && inflight_reg);

   assign count_next = {1'b0, fifo_count} + (CW+1)'(inflight_reg) - (CW+1)'(pop);

   always_comb begin
      state_next  = state_reg;
      addr_next   = addr_reg;
      num_next    = num_reg;
      issued_next = issued_reg + NW'(issue);
      popped_next = popped_reg + NW'(pop);
      will_issue  = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (start_drain) begin
               num_next    = num_words;
               addr_next   = base_addr;
               issued_next = '0;
               popped_next = '0;
               state_next  = (num_words != '0) ? READ : FIN;
            end
         end
         READ: begin
            if (issue && ((issued_reg + 1'b1) == num_reg)) begin
               state_next = FLUSH;
            end
            // The address only moves right before the next read issues, so a
            // stalled drain keeps showing the last address it actually read.
            will_issue = (issued_next < num_reg) &&
                         ((count_next + (CW+1)'(issue)) < (CW+1)'(FIFO_DEPTH));
            if (will_issue) begin
               addr_next = addr_reg + 1'b1;
            end
         end
         FLUSH: begin
            if (pop && out_last) begin
               state_next = FIN;
            end
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         num_reg      <= '0;
         issued_reg   <= '0;
         popped_reg   <= '0;
         inflight_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         addr_reg     <= addr_next;
         num_reg      <= num_next;
         issued_reg   <= issued_next;
         popped_reg   <= popped_next;
         inflight_reg <= issue;
      end
   end

endmodule
